// File: rtl/pwm_mode_decoder_pkg.sv
// pwm_mode_pkg: shared definitions for the PWM mode decoder.
//   - meter_state_e : pulse-width meter FSM encoding
//   - DEF_*         : default parameter values of the relay-controller build
package pwm_mode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } meter_state_e;

    localparam int DEF_CNT_W       = 20;
    localparam int DEF_NUM_MODES   = 2;
    localparam int DEF_MODE_W      = 3;
    localparam int DEF_TOL         = 1000;
    localparam int DEF_CONFIRM     = 20;
    localparam int DEF_LOSS_CYCLES = 2000000;

    // Mode 0 occupies the least significant CNT_W bits.
    localparam logic [DEF_NUM_MODES*DEF_CNT_W-1:0] DEF_MODE_TARGETS = {20'd95000, 20'd50500};

endpackage

// File: rtl/pwm_mode_decoder_if.sv
// pwm_mode_decoder_if: bundles the PWM input and all decoder results.
//   AUX_INPUT   : raw PWM input (driven by master)
//   MODE_OUT    : confirmed mode index         MODE_VALID  : mode confirmed, signal present
//   PULSE_DONE  : one-cycle measurement strobe PULSE_WIDTH : last measured width
//   PULSE_MATCH : last pulse matched a mode    PULSE_CLASS : matched mode index
//   LOSS        : input stuck low
// Modports: master = signal source / observer, slave = decoder.
interface pwm_mode_decoder_if
    import pwm_mode_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int MODE_W = DEF_MODE_W
);
    logic              AUX_INPUT;
    logic [MODE_W-1:0] MODE_OUT;
    logic              MODE_VALID;
    logic              PULSE_DONE;
    logic [CNT_W-1:0]  PULSE_WIDTH;
    logic              PULSE_MATCH;
    logic [MODE_W-1:0] PULSE_CLASS;
    logic              LOSS;

    modport master (
        output AUX_INPUT,
        input  MODE_OUT, MODE_VALID, PULSE_DONE, PULSE_WIDTH, PULSE_MATCH, PULSE_CLASS, LOSS
    );

    modport slave (
        input  AUX_INPUT,
        output MODE_OUT, MODE_VALID, PULSE_DONE, PULSE_WIDTH, PULSE_MATCH, PULSE_CLASS, LOSS
    );
endinterface

// File: rtl/pwm_mode_decoder_pulse_width_meter.sv
// pulse_width_meter: synchronises the PWM input, measures each high pulse and
// watches for a stuck-low input.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   aux_i         : asynchronous PWM input
//   strobe_o      : one cycle, a width is available (normal end or overflow)
//   width_o       : measured width, valid with strobe_o
//   ovf_o         : the strobe reports a saturated (overflowed) pulse
//   loss_o        : registered loss-of-signal level
//   loss_hit_o    : loss is being declared this cycle
module pulse_width_meter
    import pwm_mode_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOSS_CYCLES = DEF_LOSS_CYCLES
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             aux_i,
    output logic             strobe_o,
    output logic [CNT_W-1:0] width_o,
    output logic             ovf_o,
    output logic             loss_o,
    output logic             loss_hit_o
);
    localparam int               LOW_W    = $clog2(LOSS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LOW_W-1:0] LOSS_MAX = LOW_W'(LOSS_CYCLES);
    localparam logic [LOW_W-1:0] LOSS_PRE = LOW_W'(LOSS_CYCLES - 1);

    meter_state_e     state_q, state_d;
    logic             sync1_q, sync2_q, dly_q;
    logic [1:0]       prime_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LOW_W-1:0] low_q, low_d;
    logic             loss_q, loss_d;
    logic             armed_s, rise_s, fall_s, sat_s, strobe_s, ovf_s, loss_hit_s;

    // Edges are suppressed until the synchroniser and edge flop have refilled
    // after reset, so an input already high at release is never taken as a rise.
    assign armed_s    = (prime_q == 2'd3);
    assign rise_s     = armed_s & sync2_q & ~dly_q;
    assign fall_s     = armed_s & ~sync2_q & dly_q;
    assign sat_s      = (cnt_q == CNT_MAX);
    assign loss_hit_s = ~sync2_q & (low_q == LOSS_PRE);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a falling edge wins over saturation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) state_d = ST_HIGH;
                else        state_d = ST_IDLE;
            end
            ST_HIGH: begin
                if (fall_s)     state_d = ST_IDLE;
                else if (sat_s) state_d = ST_WAIT_LOW;
                else            state_d = ST_HIGH;
            end
            ST_WAIT_LOW: begin
                if (fall_s) state_d = ST_IDLE;
                else        state_d = ST_WAIT_LOW;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: width counter update and measurement strobe.
    always_comb begin
        strobe_s = 1'b0;
        ovf_s    = 1'b0;
        cnt_d    = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = rise_s ? CNT_W'(1) : '0;
            end
            ST_HIGH: begin
                if (fall_s) begin
                    strobe_s = 1'b1;
                end else if (sat_s) begin
                    strobe_s = 1'b1;
                    ovf_s    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOW: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Low-run counter saturates at the loss threshold; loss clears on a rise.
    always_comb begin
        if (sync2_q) begin
            low_d = '0;
        end else if (low_q == LOSS_MAX) begin
            low_d = LOSS_MAX;
        end else begin
            low_d = low_q + LOW_W'(1);
        end
        if (rise_s) begin
            loss_d = 1'b0;
        end else if (loss_hit_s) begin
            loss_d = 1'b1;
        end else begin
            loss_d = loss_q;
        end
    end

    // Synchroniser, edge flop, settle counter and measurement registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            prime_q <= 2'd0;
            cnt_q   <= '0;
            low_q   <= '0;
            loss_q  <= 1'b0;
        end else begin
            sync1_q <= aux_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            prime_q <= armed_s ? prime_q : prime_q + 2'd1;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            loss_q  <= loss_d;
        end
    end

    assign strobe_o   = strobe_s;
    assign width_o    = cnt_q;
    assign ovf_o      = ovf_s;
    assign loss_o     = loss_q;
    assign loss_hit_o = loss_hit_s;

endmodule

// File: rtl/pwm_mode_decoder.sv
// pwm_mode_decoder: classifies measured PWM pulse widths against NUM_MODES
// targets and switches the relay mode after CONFIRM consecutive agreeing pulses.
//   CLOCK_50 : system clock        RESET_N : asynchronous active-low reset
//   bus      : slave side of pwm_mode_decoder_if (AUX_INPUT in, results out)
module pwm_mode_decoder
    import pwm_mode_pkg::*;
#(
    parameter int                          CNT_W        = DEF_CNT_W,
    parameter int                          NUM_MODES    = DEF_NUM_MODES,
    parameter int                          MODE_W       = DEF_MODE_W,
    parameter logic [NUM_MODES*CNT_W-1:0]  MODE_TARGETS = DEF_MODE_TARGETS,
    parameter int                          TOL          = DEF_TOL,
    parameter int                          CONFIRM      = DEF_CONFIRM,
    parameter int                          LOSS_CYCLES  = DEF_LOSS_CYCLES
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    pwm_mode_decoder_if.slave   bus
);
    localparam int                  STREAK_W   = $clog2(CONFIRM + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CONFIRM);
    localparam logic [CNT_W:0]      TOL_W      = (CNT_W+1)'(TOL);

    // Distance between two widths, one bit wider so it never wraps.
    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] ae;
        logic [CNT_W:0] be;
        ae = {1'b0, a};
        be = {1'b0, b};
        return (ae >= be) ? (ae - be) : (be - ae);
    endfunction

    logic                 strobe_s, ovf_s, loss_s, loss_hit_s, match_s;
    logic [CNT_W-1:0]     width_s;
    logic [NUM_MODES-1:0] hit_s;
    logic [MODE_W-1:0]    class_s;

    logic                 done_q, done_d, match_q, match_d, mode_valid_q, mode_valid_d;
    logic [CNT_W-1:0]     width_q, width_d;
    logic [MODE_W-1:0]    class_q, class_d, cand_q, cand_d, mode_out_q, mode_out_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;

    pulse_width_meter #(
        .CNT_W       (CNT_W),
        .LOSS_CYCLES (LOSS_CYCLES)
    ) u_meter (
        .clk_i      (CLOCK_50),
        .rst_ni     (RESET_N),
        .aux_i      (bus.AUX_INPUT),
        .strobe_o   (strobe_s),
        .width_o    (width_s),
        .ovf_o      (ovf_s),
        .loss_o     (loss_s),
        .loss_hit_o (loss_hit_s)
    );

    // Tolerance-window classification; scanning downward lets the lowest index win.
    always_comb begin
        hit_s   = '0;
        class_s = '0;
        for (int k = NUM_MODES - 1; k >= 0; k--) begin
            hit_s[k] = (abs_diff(width_s, MODE_TARGETS[k*CNT_W +: CNT_W]) <= TOL_W);
            class_s  = hit_s[k] ? MODE_W'(k) : class_s;
        end
        match_s = (|hit_s) & ~ovf_s;
    end

    // Confirmation: streak of identical matches; garbage and loss break the streak.
    always_comb begin
        done_d       = strobe_s;
        width_d      = width_q;
        match_d      = match_q;
        class_d      = class_q;
        cand_d       = cand_q;
        streak_d     = streak_q;
        mode_out_d   = mode_out_q;
        mode_valid_d = mode_valid_q;
        if (strobe_s) begin
            width_d = width_s;
            match_d = match_s;
            class_d = match_s ? class_s : '0;
            if (match_s) begin
                if (class_s == cand_q) begin
                    streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + STREAK_W'(1);
                end else begin
                    cand_d   = class_s;
                    streak_d = STREAK_W'(1);
                end
                if (streak_d == STREAK_MAX) begin
                    mode_out_d   = cand_d;
                    mode_valid_d = 1'b1;
                end else begin
                    mode_out_d   = mode_out_q;
                end
            end else begin
                streak_d = '0;
            end
        end else if (loss_hit_s) begin
            streak_d     = '0;
            mode_valid_d = 1'b0;
        end else begin
            done_d = 1'b0;
        end
    end

    // Result and confirmation registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            done_q       <= 1'b0;
            width_q      <= '0;
            match_q      <= 1'b0;
            class_q      <= '0;
            cand_q       <= '0;
            streak_q     <= '0;
            mode_out_q   <= '0;
            mode_valid_q <= 1'b0;
        end else begin
            done_q       <= done_d;
            width_q      <= width_d;
            match_q      <= match_d;
            class_q      <= class_d;
            cand_q       <= cand_d;
            streak_q     <= streak_d;
            mode_out_q   <= mode_out_d;
            mode_valid_q <= mode_valid_d;
        end
    end

    assign bus.PULSE_DONE  = done_q;
    assign bus.PULSE_WIDTH = width_q;
    assign bus.PULSE_MATCH = match_q;
    assign bus.PULSE_CLASS = class_q;
    assign bus.MODE_OUT    = mode_out_q;
    assign bus.MODE_VALID  = mode_valid_q;
    assign bus.LOSS        = loss_s;

endmodule

// File: tb/tb_pwm_mode_decoder.sv
// Testbench for pwm_mode_decoder using a scaled-down build (8-bit counter,
// three modes, short loss timeout) so every scenario fits in a short run.
module tb_pwm_mode_decoder;
    localparam int CNT_W       = 8;
    localparam int NUM_MODES   = 3;
    localparam int MODE_W      = 2;
    localparam int TOL         = 4;
    localparam int CONFIRM     = 3;
    localparam int LOSS_CYCLES = 300;
    localparam int SAT         = 255;
    localparam logic [NUM_MODES*CNT_W-1:0] TARGETS = {8'd97, 8'd90, 8'd40};

    int tgt [NUM_MODES] = '{40, 90, 97};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model: recent classification results since last reset/loss.
    int hist[$];
    int mout = 0;
    int mval = 0;

    typedef struct { int w; int m; int c; int mo; int mv; int ls; } ev_t;
    ev_t evq[$];

    pwm_mode_decoder_if #(.CNT_W(CNT_W), .MODE_W(MODE_W)) bus ();

    pwm_mode_decoder #(
        .CNT_W        (CNT_W),
        .NUM_MODES    (NUM_MODES),
        .MODE_W       (MODE_W),
        .MODE_TARGETS (TARGETS),
        .TOL          (TOL),
        .CONFIRM      (CONFIRM),
        .LOSS_CYCLES  (LOSS_CYCLES)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Record every measurement strobe together with the mode state at that moment.
    always @(negedge clk) begin
        ev_t e;
        if (bus.PULSE_DONE === 1'b1) begin
            e.w  = int'(bus.PULSE_WIDTH);
            e.m  = int'(bus.PULSE_MATCH);
            e.c  = int'(bus.PULSE_CLASS);
            e.mo = int'(bus.MODE_OUT);
            e.mv = int'(bus.MODE_VALID);
            e.ls = int'(bus.LOSS);
            evq.push_back(e);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void classify(input int n, output int m, output int c);
        m = 0;
        c = 0;
        if (n <= SAT) begin
            for (int k = NUM_MODES - 1; k >= 0; k--) begin
                if (((n > tgt[k]) ? n - tgt[k] : tgt[k] - n) <= TOL) begin
                    m = 1;
                    c = k;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        hist.delete();
        mout = 0;
        mval = 0;
    endfunction

    // Drive one high pulse of n cycles followed by gap low cycles, then check.
    task automatic run_pulse(input int n, input int gap);
        ev_t e;
        int  m, c, loss_exp;
        bit  same;
        evq.delete();
        @(negedge clk);
        bus.AUX_INPUT = 1'b1;
        repeat (n) @(negedge clk);
        bus.AUX_INPUT = 1'b0;
        repeat (gap) @(negedge clk);

        classify(n, m, c);
        hist.push_back((m != 0) ? c : -1);
        if (hist.size() > CONFIRM) void'(hist.pop_front());
        same = (hist.size() == CONFIRM);
        foreach (hist[i]) same = same && (hist[i] == hist[0]) && (hist[i] >= 0);
        if (same) begin
            mout = hist[0];
            mval = 1;
        end

        check_eq("strobe_count", evq.size(), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check_eq("pulse_width", e.w, (n > SAT) ? SAT : n);
            check_eq("pulse_match", e.m, m);
            check_eq("pulse_class", e.c, (m != 0) ? c : 0);
            check_eq("mode_out_at_done", e.mo, mout);
            check_eq("mode_valid_at_done", e.mv, mval);
            check_eq("loss_at_done", e.ls, 0);
        end

        loss_exp = (gap >= LOSS_CYCLES + 8) ? 1 : 0;
        check_eq("loss_after_gap", bus.LOSS, loss_exp);
        if (loss_exp != 0) begin
            hist.delete();
            mval = 0;
        end
        check_eq("mode_valid_after_gap", bus.MODE_VALID, mval);
        check_eq("mode_out_after_gap", bus.MODE_OUT, mout);
    endtask

    int dir_w [18] = '{40, 40, 40, 90, 90, 30, 90, 90, 90, 36, 44, 35, 45, 93, 255, 300, 256, 1};

    initial begin
        int fav, sel, n, gap;
        bus.AUX_INPUT = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mode_out", bus.MODE_OUT, 0);
        check_eq("rst_mode_valid", bus.MODE_VALID, 0);
        check_eq("rst_pulse_done", bus.PULSE_DONE, 0);
        check_eq("rst_pulse_width", bus.PULSE_WIDTH, 0);
        check_eq("rst_pulse_match", bus.PULSE_MATCH, 0);
        check_eq("rst_pulse_class", bus.PULSE_CLASS, 0);
        check_eq("rst_loss", bus.LOSS, 0);

        repeat (LOSS_CYCLES + 10) @(negedge clk);
        check_eq("idle_loss", bus.LOSS, 1);
        check_eq("idle_mode_valid", bus.MODE_VALID, 0);

        // Confirmation, garbage interruption, tolerance edges, overlap, overflow.
        foreach (dir_w[i]) run_pulse(dir_w[i], 20);

        // Confirm mode 1 again, then lose the signal and recover.
        run_pulse(90, 20);
        run_pulse(90, 20);
        run_pulse(90, LOSS_CYCLES + 30);
        run_pulse(90, 20);

        // Reset in the middle of a pulse with the input still high at release.
        evq.delete();
        @(negedge clk);
        bus.AUX_INPUT = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        bus.AUX_INPUT = 1'b0;
        repeat (20) @(negedge clk);
        model_reset();
        check_eq("midrst_no_strobe", evq.size(), 0);
        check_eq("midrst_mode_out", bus.MODE_OUT, 0);
        check_eq("midrst_mode_valid", bus.MODE_VALID, 0);
        check_eq("midrst_pulse_width", bus.PULSE_WIDTH, 0);
        run_pulse(40, 20);

        // Randomised pulses biased towards a slowly changing favourite mode.
        fav = 0;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) fav = int'($urandom_range(0, NUM_MODES - 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 7) n = tgt[fav] + int'($urandom_range(0, 2*TOL + 2)) - (TOL + 1);
            else if (sel < 9) n = int'($urandom_range(1, SAT));
            else n = int'($urandom_range(SAT + 1, SAT + 60));
            gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(LOSS_CYCLES + 20, LOSS_CYCLES + 60))
                                               : int'($urandom_range(8, 60));
            run_pulse(n, gap);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
